// File: rtl/sort_irq_ctrl.sv
// Per-channel sorter pass monitor: counts consecutive clean (swap-free) passes,
// raises sticky pending/overrun flags at a threshold and drives a combined interrupt.
module sort_irq_ctrl #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 4,
  parameter int IRQ_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  run_i,
  input  logic [N_CH-1:0]  swap_i,
  input  logic [CNT_W-1:0] thr_i,
  input  logic [N_CH-1:0]  mask_i,
  input  logic [N_CH-1:0]  clr_i,
  output logic [N_CH-1:0]  done_o,
  output logic [N_CH-1:0]  pend_o,
  output logic [N_CH-1:0]  ovf_o,
  output logic             irq_o
);

  localparam logic [CNT_W:0]   ONE_X = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = ONE_X[CNT_W-1:0];

  logic [N_CH-1:0]  run_r, dirty_r, done_r, pend_r, ovf_r;
  logic [CNT_W-1:0] cnt_r     [N_CH];
  logic [CNT_W-1:0] cnt_nxt_s [N_CH];
  logic [N_CH-1:0]  pass_end_s, clean_s, hit_s;
  logic [CNT_W:0]   eff_thr_s;
  logic             any_s, any_prev_r, irq_r;

  assign pass_end_s = run_r & ~run_i;
  // A swap in the pass-end cycle itself still spoils the ending pass.
  assign clean_s    = pass_end_s & ~dirty_r & ~swap_i;
  assign eff_thr_s  = (thr_i == {CNT_W{1'b0}}) ? ONE_X : {1'b0, thr_i};
  assign any_s      = |(pend_r & mask_i);

  // Clean-pass counter next state; compare is >= so a lowered threshold hits immediately
  always_comb begin
    hit_s = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      cnt_nxt_s[c] = cnt_r[c];
      if (clean_s[c]) begin
        if (({1'b0, cnt_r[c]} + ONE_X) >= eff_thr_s) begin
          hit_s[c]     = 1'b1;
          cnt_nxt_s[c] = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s[c] = cnt_r[c] + ONE_C;
        end
      end else if (pass_end_s[c]) begin
        cnt_nxt_s[c] = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[c] = cnt_r[c];
      end
    end
  end

  // State registers; flag sets take priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r      <= {N_CH{1'b0}};
      dirty_r    <= {N_CH{1'b0}};
      done_r     <= {N_CH{1'b0}};
      pend_r     <= {N_CH{1'b0}};
      ovf_r      <= {N_CH{1'b0}};
      any_prev_r <= 1'b0;
      irq_r      <= 1'b0;
      for (int c = 0; c < N_CH; c++) cnt_r[c] <= {CNT_W{1'b0}};
    end else begin
      run_r      <= run_i;
      dirty_r    <= ~pass_end_s & (dirty_r | (swap_i & run_i));
      done_r     <= clean_s;
      pend_r     <= hit_s | (pend_r & ~clr_i);
      ovf_r      <= (hit_s & pend_r) | (ovf_r & ~clr_i);
      any_prev_r <= any_s;
      irq_r      <= (IRQ_MODE == 1) ? (any_s & ~any_prev_r) : any_s;
      for (int c = 0; c < N_CH; c++) cnt_r[c] <= cnt_nxt_s[c];
    end
  end

  assign done_o = done_r;
  assign pend_o = pend_r;
  assign ovf_o  = ovf_r;
  assign irq_o  = irq_r;

endmodule

// File: tb/tb_sort_irq_ctrl.sv
// Directed self-checking bench for sort_irq_ctrl: a level-mode and a pulse-mode
// instance share all inputs; expected values are hand-derived per scenario.
module tb_sort_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] run_i, swap_i, mask_i, clr_i, thr_i;
  logic [3:0] done0, pend0, ovf0, done1, pend1, ovf1;
  logic       irq0, irq1;
  int         n_checks = 0;
  int         n_err    = 0;

  always #5 clk = ~clk;

  sort_irq_ctrl #(.N_CH(4), .CNT_W(4), .IRQ_MODE(0)) u0 (
    .clk(clk), .rst(rst), .run_i(run_i), .swap_i(swap_i), .thr_i(thr_i),
    .mask_i(mask_i), .clr_i(clr_i), .done_o(done0), .pend_o(pend0),
    .ovf_o(ovf0), .irq_o(irq0));

  sort_irq_ctrl #(.N_CH(4), .CNT_W(4), .IRQ_MODE(1)) u1 (
    .clk(clk), .rst(rst), .run_i(run_i), .swap_i(swap_i), .thr_i(thr_i),
    .mask_i(mask_i), .clr_i(clr_i), .done_o(done1), .pend_o(pend1),
    .ovf_o(ovf1), .irq_o(irq1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run-high cycle then the pass-end cycle; returns just after the T+1 edge.
  task automatic do_pass(input logic [3:0] ch, input logic [3:0] sw_run,
                         input logic [3:0] sw_end, input logic [3:0] clr);
    run_i = ch;  swap_i = sw_run; clr_i = 4'b0000;
    tick();
    run_i = 4'b0000; swap_i = sw_end; clr_i = clr;
    tick();
    swap_i = 4'b0000; clr_i = 4'b0000;
  endtask

  task automatic clear_all();
    clr_i = 4'b1111;
    tick();
    clr_i = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; run_i = 4'b0001; swap_i = 4'b0000; thr_i = 4'd3;
    mask_i = 4'b0001; clr_i = 4'b0000;
    tick(); tick();
    check("rst_done", done0, 4'b0000);
    check("rst_pend", pend0, 4'b0000);
    check("rst_ovf",  ovf0,  4'b0000);
    check("rst_irq0", irq0,  1'b0);
    check("rst_irq1", irq1,  1'b0);

    // Run high during reset must not yield a pass end right after release
    rst = 1'b0; run_i = 4'b0000;
    tick();
    check("no_pass_after_rst", done0, 4'b0000);

    // Basic: three clean passes at thr=3
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("basic_done1", done0, 4'b0001);
    check("basic_pend1", pend0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("basic_done2", done0, 4'b0001);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("basic_done3", done0, 4'b0001);
    check("basic_pend3", pend0, 4'b0001);
    check("basic_irq_lag", irq0, 1'b0);
    tick();
    check("done_one_cycle", done0, 4'b0000);
    check("basic_irq0", irq0, 1'b1);
    check("pulse_on", irq1, 1'b1);
    tick();
    check("level_hold", irq0, 1'b1);
    check("pulse_off", irq1, 1'b0);
    clr_i = 4'b0001;
    tick();
    clr_i = 4'b0000;
    check("clr_pend", pend0, 4'b0000);
    tick();
    check("clr_irq0", irq0, 1'b0);

    // Dirty pass in the middle resets the count
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    do_pass(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    check("dirty_no_done", done0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("dirty_no_pend", pend0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("dirty_then_pend", pend0, 4'b0001);

    // Overrun with thr=0 (treated as 1), then set-beats-clear
    thr_i = 4'd0;
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("ovf_set", ovf0, 4'b0001);
    check("ovf_pend_stays", pend0, 4'b0001);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    check("set_wins_pend", pend0, 4'b0001);
    check("set_wins_ovf", ovf0, 4'b0001);
    clr_i = 4'b0001;
    tick();
    clr_i = 4'b0000;
    check("clr_both_pend", pend0, 4'b0000);
    check("clr_both_ovf", ovf0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("thr0_pend", pend0, 4'b0001);
    check("thr0_no_ovf", ovf0, 4'b0000);

    // Swap in the pass-end cycle spoils only the ending pass
    clear_all();
    thr_i = 4'd1;
    do_pass(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    check("end_swap_done", done0, 4'b0000);
    check("end_swap_pend", pend0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("after_end_swap", pend0, 4'b0001);

    // Lowered threshold hits on the next clean pass
    clear_all();
    thr_i = 4'd3;
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("lower_pre", pend0, 4'b0000);
    thr_i = 4'd1;
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("lower_hit", pend0, 4'b0001);

    // Back-to-back pass ends on ch1 (run 1,0,1,0)
    clear_all();
    run_i = 4'b0010; tick();
    run_i = 4'b0000; tick();
    check("b2b_done_a", done0, 4'b0010);
    run_i = 4'b0010; tick();
    check("b2b_gap", done0, 4'b0000);
    run_i = 4'b0000; tick();
    check("b2b_done_b", done0, 4'b0010);
    check("b2b_pend", pend0, 4'b0010);

    // All channels at once, mask only ch2
    clr_i = 4'b1111; mask_i = 4'b0100;
    tick();
    clr_i = 4'b0000;
    tick(); tick();
    check("multi_idle_irq", irq0, 1'b0);
    do_pass(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    check("multi_done", done0, 4'b1111);
    check("multi_pend", pend0, 4'b1111);
    tick();
    check("multi_irq0", irq0, 1'b1);
    check("multi_irq1", irq1, 1'b1);
    clr_i = 4'b0100;
    tick();
    clr_i = 4'b0000;
    check("multi_clr2", pend0, 4'b1011);
    tick();
    check("multi_irq_off", irq0, 1'b0);
    mask_i = 4'b0001;
    tick();
    check("unmask_irq0", irq0, 1'b1);
    check("unmask_irq1", irq1, 1'b1);
    check("unmask_pend", pend0, 4'b1011);
    check("u1_pend", pend1, 4'b1011);
    check("u1_ovf", ovf1, 4'b0000);
    check("u1_done", done1, 4'b0000);

    // Reset during a swapped pass must not taint the next pass
    clear_all();
    run_i = 4'b0001; swap_i = 4'b0001;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_pend", pend0, 4'b0000);
    check("midrst_irq", irq0, 1'b0);
    rst = 1'b0; run_i = 4'b0000; swap_i = 4'b0000;
    tick();
    check("midrst_no_pass", done0, 4'b0000);
    do_pass(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    check("post_rst_done", done0, 4'b0001);
    check("post_rst_pend", pend0, 4'b0001);
    check("post_rst_pend1", pend1, 4'b0001);
    tick();
    check("post_rst_pulse", irq1, 1'b1);
    tick();
    check("post_rst_pulse_end", irq1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
